// File: rtl/fft_mag_writer_if.sv
// fft_mag_writer_if: FFT bin stream, VGA buffer write port and max-search handshake
interface fft_mag_writer_if #(
  parameter int ADDR_W   = 10,
  parameter int SAMPLE_W = 32,
  parameter int DATA_W   = 64
);
  logic                fft_valid_i;
  logic                fft_sop_i;
  logic [SAMPLE_W-1:0] fft_re_i;
  logic [SAMPLE_W-1:0] fft_im_i;
  logic                fft_ready_o;
  logic                write_vga_buff_en_o;
  logic [ADDR_W-1:0]   write_vga_buff_add_o;
  logic [DATA_W-1:0]   write_vga_buff_data_o;
  logic                vga_start_o;
  logic                max_found_i;
  logic                frame_err_o;
  modport slave (
    input  fft_valid_i, fft_sop_i, fft_re_i, fft_im_i, max_found_i,
    output fft_ready_o, write_vga_buff_en_o, write_vga_buff_add_o, write_vga_buff_data_o,
           vga_start_o, frame_err_o
  );
  modport master (
    output fft_valid_i, fft_sop_i, fft_re_i, fft_im_i, max_found_i,
    input  fft_ready_o, write_vga_buff_en_o, write_vga_buff_add_o, write_vga_buff_data_o,
           vga_start_o, frame_err_o
  );
endinterface

// File: rtl/fft_mag_writer.sv
// fft_mag_writer: writes squared magnitude of each FFT bin to the VGA buffer, then hands the frame to max search
module fft_mag_writer #(
  parameter int N_POINTS = 1024,
  parameter int ADDR_W   = 10,
  parameter int SAMPLE_W = 32,
  parameter int DATA_W   = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  fft_mag_writer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, FILL, FLUSH, START, WAIT_MAX} state_t;
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_POINTS - 1);
  state_t                    r_state, w_nxt;
  logic [ADDR_W-1:0]         r_cnt, w_cnt, w_add;
  logic                      w_we, w_err, w_acc, w_sop, w_last;
  logic                      r_ready, r_start, r_err;
  logic                      r_v1, r_we;
  logic [ADDR_W-1:0]         r_a1, r_add;
  logic [DATA_W-1:0]         r_re2, r_im2, r_data;
  logic signed [DATA_W-1:0]  w_re, w_im;
  assign w_acc  = bus.fft_valid_i && r_ready;
  assign w_sop  = bus.fft_sop_i;
  assign w_last = !w_sop && (r_cnt == LAST);
  assign w_re   = DATA_W'($signed(bus.fft_re_i));
  assign w_im   = DATA_W'($signed(bus.fft_im_i));
  // next state, bin counter and the write request for the accepted bin
  always_comb begin
    w_nxt = r_state;
    w_cnt = r_cnt;
    w_add = r_cnt;
    w_we  = 1'b0;
    w_err = 1'b0;
    case (r_state)
      IDLE: if (w_acc && w_sop) begin
        w_we  = 1'b1;
        w_add = '0;
        w_cnt = ONE;
        w_nxt = FILL;
      end
      FILL: if (w_acc) begin
        w_we  = 1'b1;
        w_err = w_sop;
        w_add = w_sop ? '0 : r_cnt;
        w_cnt = w_sop ? ONE : (w_last ? '0 : r_cnt + ONE);
        w_nxt = w_last ? FLUSH : FILL;
      end
      FLUSH: begin
        w_cnt = r_cnt + ONE;
        w_nxt = r_cnt[0] ? START : FLUSH;
      end
      START: begin
        w_cnt = '0;
        w_nxt = WAIT_MAX;
      end
      WAIT_MAX: if (bus.max_found_i) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end
  // state register and registered control outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_start <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt;
      r_ready <= (w_nxt == IDLE) || (w_nxt == FILL);
      r_start <= w_nxt == START;
      r_err   <= w_err;
    end
  end
  // two-stage square-and-sum pipeline; address and strobe ride alongside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_a1   <= '0;
      r_re2  <= '0;
      r_im2  <= '0;
      r_we   <= 1'b0;
      r_add  <= '0;
      r_data <= '0;
    end else begin
      r_v1   <= w_we;
      r_a1   <= w_add;
      r_re2  <= w_re * w_re;
      r_im2  <= w_im * w_im;
      r_we   <= r_v1;
      r_add  <= r_a1;
      r_data <= r_re2 + r_im2;
    end
  end
  assign bus.fft_ready_o           = r_ready;
  assign bus.write_vga_buff_en_o   = r_we;
  assign bus.write_vga_buff_add_o  = r_add;
  assign bus.write_vga_buff_data_o = r_data;
  assign bus.vga_start_o           = r_start;
  assign bus.frame_err_o           = r_err;
endmodule
